imem_boot_loader: RTL and testbench

//  Instruction memory plus boot-load controller. Sits directly upstream of the

---
 rtl/imem_boot_loader.sv | 154 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Instruction RAM with a boot-load controller that holds the CPU in reset while a program streams in.
// Latency: a word written at edge N is visible on instr from N+1; the fetch path is combinational from pc.
// Backpressure: in_ready is registered and stays high only while in LOAD, so no word is taken in any other state.
module imem_boot_loader #(
    parameter int          AW       = 8,
    parameter int          HOLD_CYC = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          in_ready,
    input  logic [31:0]   pc,
    output logic [31:0]   instr,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          len_err,
    output logic          fetch_err
);

    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW:0] DEPTH_LEN = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_LEN   = (AW + 1)'(1);
    localparam int          HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t         state_q;
    logic [AW:0]    len_q;
    logic [AW:0]    wr_ptr_q;
    logic [HW-1:0]  hold_cnt_q;
    logic           cpu_rst_q;
    logic           in_ready_q;
    logic           busy_q;
    logic           done_q;
    logic           len_err_q;

    logic [31:0]    mem [DEPTH];

    logic           wr_fire;
    logic           len_zero;
    logic           len_ok;
    logic           len_big;
    logic           last_word;

    assign wr_fire   = (state_q == S_LOAD) && in_ready_q && in_valid;
    assign len_zero  = (len == '0);
    assign len_big   = (len > DEPTH_LEN);
    assign len_ok    = !len_zero && !len_big;
    assign last_word = (wr_ptr_q == (len_q - ONE_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            cpu_rst_q  <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            case (state_q)
                // IDLE and RUN react to start identically; cpu_rst is already high in IDLE.
                S_IDLE, S_RUN: begin
                    if (start) begin
                        if (len_big) begin
                            len_err_q <= 1'b1;
                        end else if (len_zero) begin
                            state_q    <= S_RELEASE;
                            hold_cnt_q <= '0;
                            cpu_rst_q  <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                        end else if (len_ok) begin
                            state_q    <= S_LOAD;
                            len_q      <= len;
                            wr_ptr_q   <= '0;
                            cpu_rst_q  <= 1'b1;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (wr_fire) begin
                        wr_ptr_q <= wr_ptr_q + ONE_LEN;
                        if (last_word) begin
                            state_q    <= S_RELEASE;
                            in_ready_q <= 1'b0;
                            hold_cnt_q <= '0;
                        end
                    end
                end
                S_RELEASE: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= S_RUN;
                        hold_cnt_q <= '0;
                        cpu_rst_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // RAM contents deliberately survive rst so a partial reload keeps the tail of the old program.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    logic pc_aligned;
    logic pc_in_range;
    logic run;

    assign pc_aligned  = (pc[1:0] == 2'b00);
    assign pc_in_range = (pc[31:AW+2] == '0);
    assign run         = (state_q == S_RUN);

    always_comb begin
        instr = NOP_WORD;
        if (run && pc_aligned && pc_in_range) begin
            instr = mem[pc[AW+1:2]];
        end
    end

    assign fetch_err = run && !(pc_aligned && pc_in_range);
    assign in_ready  = in_ready_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: load, gapped load, length limits, fetch guards, mid-load reset, reload control.
module tb_imem_boot_loader;

    localparam int          AW    = 8;
    localparam int          DEPTH = 256;
    localparam int          HOLD  = 2;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [AW:0] len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        len_err;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    imem_boot_loader #(.AW(AW), .HOLD_CYC(HOLD), .NOP_WORD(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .pc        (pc),
        .instr     (instr),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .len_err   (len_err),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    // Streams words; optionally applies the valid pattern 1,0,0,1,0,1 then holds valid high.
    task automatic stream(input logic [31:0] words[$], input bit gapped, output int rdy_cyc, output int acc);
        logic [5:0] pat = 6'b101001;
        int k = 0;
        logic r;
        logic v;
        acc = 0;
        rdy_cyc = 0;
        while (acc < words.size() && k < 1000) begin
            in_valid = (gapped && k < 6) ? pat[k] : 1'b1;
            in_data  = words[acc];
            r = in_ready;
            v = in_valid;
            tick();
            if (r) rdy_cyc++;
            if (r && v) acc++;
            k++;
        end
        in_valid = 1'b0;
        checks++;
        if (acc != words.size()) begin
            errors++;
            $display("FAIL stream_timeout accepted=%0d expected=%0d", acc, words.size());
        end
    endtask

    task automatic wait_run(output int hc);
        int n = 0;
        hc = 0;
        while (!done && n < 20) begin
            if (cpu_rst) hc++;
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_run_timeout done=%b required=1", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; pc = '0;
        repeat (2) tick();
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst got=%b exp=1", cpu_rst); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if ({busy, done, len_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {busy, done, len_err}); end
        checks++; if (instr !== NOP || fetch_err !== 1'b0) begin errors++; $display("FAIL rst_fetch instr=%h ferr=%b exp=%h/0", instr, fetch_err, NOP); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_load();
        logic [31:0] q[$];
        int rc, ac, hc;
        q.push_back(32'hAAAA_0001); q.push_back(32'hBBBB_0002); q.push_back(32'hCCCC_0003);
        do_start(3);
        checks++; if ({in_ready, busy, cpu_rst} !== 3'b111) begin errors++; $display("FAIL t1_enter_load got=%b exp=111", {in_ready, busy, cpu_rst}); end
        stream(q, 1'b0, rc, ac);
        checks++; if (rc != 3) begin errors++; $display("FAIL t1_ready_cycles got=%0d exp=3", rc); end
        checks++; if (in_ready !== 1'b0 || cpu_rst !== 1'b1) begin errors++; $display("FAIL t1_release rdy=%b crst=%b exp=0/1", in_ready, cpu_rst); end
        wait_run(hc);
        checks++; if (hc != HOLD) begin errors++; $display("FAIL t1_hold_cycles got=%0d exp=%0d", hc, HOLD); end
        checks++; if ({cpu_rst, busy, done} !== 3'b001) begin errors++; $display("FAIL t1_run_flags got=%b exp=001", {cpu_rst, busy, done}); end
        for (int i = 0; i < 3; i++) begin
            pc = 32'(4 * i); #1;
            checks++; if (instr !== q[i]) begin errors++; $display("FAIL t1_fetch pc=%0d got=%h exp=%h", pc, instr, q[i]); end
        end
    endtask

    task automatic test_gapped_load();
        logic [31:0] q[$];
        int rc, ac, hc;
        q.push_back(32'hD00D_0010); q.push_back(32'hE00E_0020); q.push_back(32'hF00F_0030);
        do_start(3);
        checks++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL t2_reassert crst=%b done=%b exp=1/0", cpu_rst, done); end
        stream(q, 1'b1, rc, ac);
        checks++; if (rc != 6) begin errors++; $display("FAIL t2_ready_cycles got=%0d exp=6", rc); end
        checks++; if (dut.wr_ptr_q !== 9'd3) begin errors++; $display("FAIL t2_wr_ptr got=%0d exp=3", dut.wr_ptr_q); end
        wait_run(hc);
        for (int i = 0; i < 3; i++) begin
            pc = 32'(4 * i); #1;
            checks++; if (instr !== q[i]) begin errors++; $display("FAIL t2_fetch pc=%0d got=%h exp=%h", pc, instr, q[i]); end
        end
    endtask

    task automatic test_len_limits();
        logic [31:0] q[$];
        int rc, ac, hc;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        do_start(9'(DEPTH + 1));
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL t3_len_err got=%b exp=1", len_err); end
        tick();
        checks++; if ({in_ready, cpu_rst, busy} !== 3'b010) begin errors++; $display("FAIL t3_stay_idle got=%b exp=010", {in_ready, cpu_rst, busy}); end
        for (int i = 0; i < DEPTH; i++) q.push_back(32'hC0DE_0000 + 32'(i));
        do_start(9'(DEPTH));
        stream(q, 1'b0, rc, ac);
        checks++; if (rc != DEPTH) begin errors++; $display("FAIL t3_full_ready got=%0d exp=%0d", rc, DEPTH); end
        wait_run(hc);
        pc = 32'(4 * (DEPTH - 1)); #1;
        checks++; if (instr !== 32'hC0DE_00FF) begin errors++; $display("FAIL t3_last_word got=%h exp=c0de00ff", instr); end
        pc = 32'd0; #1;
        checks++; if (instr !== 32'hC0DE_0000) begin errors++; $display("FAIL t3_first_word got=%h exp=c0de0000", instr); end
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL t3_len_err_sticky got=%b exp=1", len_err); end
    endtask

    task automatic test_fetch_guard();
        pc = 32'd2; #1;
        checks++; if (instr !== NOP || fetch_err !== 1'b1) begin errors++; $display("FAIL t4_misaligned instr=%h ferr=%b exp=%h/1", instr, fetch_err, NOP); end
        pc = 32'(4 * DEPTH); #1;
        checks++; if (instr !== NOP || fetch_err !== 1'b1) begin errors++; $display("FAIL t4_out_of_range instr=%h ferr=%b exp=%h/1", instr, fetch_err, NOP); end
        pc = 32'd4; #1;
        checks++; if (instr !== 32'hC0DE_0001 || fetch_err !== 1'b0) begin errors++; $display("FAIL t4_valid instr=%h ferr=%b exp=c0de0001/0", instr, fetch_err); end
        do_start(9'(DEPTH + 5));
        checks++; if ({done, cpu_rst, in_ready} !== 3'b100) begin errors++; $display("FAIL t4_run_bad_len got=%b exp=100", {done, cpu_rst, in_ready}); end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] q[$];
        logic [31:0] x[$];
        int rc, ac, hc;
        q.push_back(32'h1111_0000); q.push_back(32'h2222_0001);
        do_start(4);
        stream(q, 1'b0, rc, ac);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t5_still_loading got=%b exp=1", in_ready); end
        rst = 1'b1; #1;
        checks++; if ({cpu_rst, in_ready, busy, done} !== 4'b1000) begin errors++; $display("FAIL t5_async_rst got=%b exp=1000", {cpu_rst, in_ready, busy, done}); end
        checks++; if (dut.wr_ptr_q !== 9'd0) begin errors++; $display("FAIL t5_wr_ptr got=%0d exp=0", dut.wr_ptr_q); end
        tick(); rst = 1'b0; tick();
        x.push_back(32'h5A5A_A5A5);
        do_start(1);
        stream(x, 1'b0, rc, ac);
        wait_run(hc);
        pc = 32'd0; #1;
        checks++; if (instr !== 32'h5A5A_A5A5) begin errors++; $display("FAIL t5_new_word got=%h exp=5a5aa5a5", instr); end
        pc = 32'd4; #1;
        checks++; if (instr !== 32'h2222_0001) begin errors++; $display("FAIL t5_old_word got=%h exp=22220001", instr); end
    endtask

    task automatic test_back_to_back();
        int hc;
        do_start(0);
        checks++; if ({cpu_rst, busy, done} !== 3'b110) begin errors++; $display("FAIL t6_zero_release got=%b exp=110", {cpu_rst, busy, done}); end
        wait_run(hc);
        checks++; if (hc != HOLD) begin errors++; $display("FAIL t6_zero_hold got=%0d exp=%0d", hc, HOLD); end
        pc = 32'd0; #1;
        checks++; if (instr !== 32'h5A5A_A5A5) begin errors++; $display("FAIL t6_ram_kept got=%h exp=5a5aa5a5", instr); end
        do_start(2);
        start = 1'b1; len = 9'd5; in_valid = 1'b1; in_data = 32'h7777_0000;
        tick();
        start = 1'b0; len = '0; in_data = 32'h8888_0001;
        tick();
        in_valid = 1'b0;
        checks++; if ({in_ready, busy, cpu_rst} !== 3'b011) begin errors++; $display("FAIL t6_load_ignore_start got=%b exp=011", {in_ready, busy, cpu_rst}); end
        start = 1'b1; len = 9'd3;
        tick();
        start = 1'b0; len = '0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t6_release_ignore_start got=%b exp=0", in_ready); end
        wait_run(hc);
        pc = 32'd0; #1;
        checks++; if (instr !== 32'h7777_0000) begin errors++; $display("FAIL t6_word0 got=%h exp=77770000", instr); end
        pc = 32'd4; #1;
        checks++; if (instr !== 32'h8888_0001) begin errors++; $display("FAIL t6_word1 got=%h exp=88880001", instr); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gapped_load();
        test_len_limits();
        test_fetch_guard();
        test_reset_mid_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
